alu_seq_unit: RTL and testbench

Parametrised, handshaked ALU for the next processor revision, replacing the purely combinational ALU. It registers operands and opcode on a valid/ready input handshake and returns a registered result with Z/N/C/V flags. Single-cycle ops complete in one cycle; an optional iterative shift-add multiplier takes WIDTH cycles. It sits between the decode/register-read stage and writeback, and its ready signal stalls the front end during multiplies.

---
 rtl/alu_seq_unit_if.sv | 29 ++
 rtl/alu_seq_unit.sv | 196 +++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_unit_if.sv
// Handshake/data bundle for alu_seq_unit: operand valid/ready in, result valid/ready out.
// The master modport drives operands and consumes results; the slave modport is the ALU.
interface alu_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             illegal_op;

  modport master (
    output in_valid, a, b, alu_control, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, illegal_op
  );

  modport slave (
    input  in_valid, a, b, alu_control, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, illegal_op
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Handshaked ALU with registered result and Z/N/C/V flags (IDLE -> [MUL] -> DONE).
// Define ALU_MUL_EN to build the WIDTH-cycle shift-add multiplier for opcode 1010.
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_unit_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLT  = 4'b0101,
    OP_SLTU = 4'b0110,
    OP_SLL  = 4'b0111,
    OP_SRL  = 4'b1000,
    OP_SRA  = 4'b1001,
    OP_MUL  = 4'b1010
  } op_e;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;
`else
  typedef enum logic {IDLE, DONE} state_e;
`endif

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
    logic ill;
  } flags_t;

  function automatic flags_t mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                      input logic v, input logic ill);
    flags_t f;
    f.z   = (r == '0);
    f.n   = r[WIDTH-1];
    f.c   = c;
    f.v   = v;
    f.ill = ill;
    return f;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;

  // Single-cycle datapath works straight off the bus; only its outcome is registered.
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;

  always_comb begin
    is_sub  = (bus.alu_control == OP_SUB);
    b_eff   = is_sub ? ~bus.b : bus.b;
    sum     = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    shamt   = bus.b[SHW-1:0];
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (bus.alu_control)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_SLL:  alu_res = bus.a << shamt;
      OP_SRL:  alu_res = bus.a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.a) >>> shamt);
      // Undefined opcodes, and MUL when the multiplier is not built.
      default: alu_ill = 1'b1;
    endcase
  end

  logic mul_req;
`ifdef ALU_MUL_EN
  assign mul_req = (bus.alu_control == OP_MUL);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_nxt;
  logic [SHW-1:0]   cnt_q, cnt_d;
`else
  assign mul_req = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (mul_req) begin
`ifdef ALU_MUL_EN
            state_d  = MUL;
            mcand_d  = bus.a;
            mplier_d = bus.b;
            acc_d    = '0;
            cnt_d    = '0;
`endif
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            flags_d  = mk_flags(alu_res, alu_c, alu_v, alu_ill);
          end
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        // Radix-2: add the shifted multiplicand for each set multiplier bit, LSB first.
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = acc_nxt;
          flags_d  = mk_flags(acc_nxt, 1'b0, 1'b0, 1'b0);
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers reset asynchronously to known values; a reset mid-operation discards everything in flight.
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.result     = result_q;
  assign bus.flag_z     = flags_q.z;
  assign bus.flag_n     = flags_q.n;
  assign bus.flag_c     = flags_q.c;
  assign bus.flag_v     = flags_q.v;
  assign bus.illegal_op = flags_q.ill;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed, table-driven bench for alu_seq_unit (WIDTH=32), plus hold and mid-MUL reset sequences.
// Expectations follow ALU_MUL_EN the same way the design does.
module tb_alu_seq_unit;
  localparam int WIDTH = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3, XOR_ = 4'h4,
                         SLT = 4'h5, SLTU = 4'h6, SLL = 4'h7, SRL = 4'h8, SRA = 4'h9,
                         MUL = 4'hA;

  localparam logic [31:0] MUL_BIG_RES = MUL_EN ? 32'hFFFF_FFFF : 32'h0;
  localparam logic [4:0]  MUL_BIG_FL  = MUL_EN ? 5'b01000 : 5'b10001;
  localparam int          MUL_LAT     = MUL_EN ? WIDTH + 1 : 1;

  // fl packs the expected {z, n, c, v, illegal_op}.
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_seq_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_seq_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] flags_now();
    return {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.illegal_op};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, bus.out_valid, 1'b0);
    check({tag, " in_ready"}, bus.in_ready, 1'b1);
    check({tag, " result"}, bus.result, 32'h0);
    check({tag, " flags"}, flags_now(), 5'b0);
  endtask

  // Issue one op, measure accept-to-out_valid latency, check outputs, optionally hold, then drain.
  task automatic run_vec(input vec_t v, input string name, input int hold);
    int lat;
    int irl;
    @(negedge clk);
    check({name, " in_ready"}, bus.in_ready, 1'b1);
    bus.in_valid    = 1'b1;
    bus.a           = v.a;
    bus.b           = v.b;
    bus.alu_control = v.op;
    bus.out_ready   = 1'b0;
    @(posedge clk);
    lat = 0;
    irl = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) bus.in_valid = 1'b0;
      lat++;
      if (!bus.in_ready) irl++;
      if (bus.out_valid) break;
    end
    check({name, " out_valid"}, bus.out_valid, 1'b1);
    check({name, " latency"}, lat, v.lat);
    check({name, " in_ready low cycles"}, irl, v.lat);
    check({name, " result"}, bus.result, v.res);
    check({name, " flags"}, flags_now(), v.fl);
    for (int h = 0; h < hold; h++) begin
      // New operands offered while busy must be ignored.
      bus.in_valid    = 1'b1;
      bus.a           = 32'h1234_5678;
      bus.b           = 32'h1;
      bus.alu_control = ADD;
      @(negedge clk);
      check({name, " hold out_valid"}, bus.out_valid, 1'b1);
      check({name, " hold in_ready"}, bus.in_ready, 1'b0);
      check({name, " hold result"}, bus.result, v.res);
      check({name, " hold flags"}, flags_now(), v.fl);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, " drained out_valid"}, bus.out_valid, 1'b0);
    check({name, " drained in_ready"}, bus.in_ready, 1'b1);
  endtask

  vec_t vecs[24];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = '{ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 5'b01010, 1};
    vecs[1]  = '{SUB,  32'h5,         32'h5,         32'h0,         5'b10100, 1};
    vecs[2]  = '{SUB,  32'h0,         32'h1,         32'hFFFF_FFFF, 5'b01000, 1};
    vecs[3]  = '{SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         5'b00000, 1};
    vecs[4]  = '{SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         5'b10000, 1};
    vecs[5]  = '{SRA,  32'h8000_0000, 32'h21,        32'hC000_0000, 5'b01000, 1};
    vecs[6]  = '{AND_, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 5'b00000, 1};
    vecs[7]  = '{OR_,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 5'b01000, 1};
    vecs[8]  = '{XOR_, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 5'b00000, 1};
    vecs[9]  = '{SLL,  32'h1,         32'h1F,        32'h8000_0000, 5'b01000, 1};
    vecs[10] = '{SRL,  32'h8000_0000, 32'h24,        32'h0800_0000, 5'b00000, 1};
    vecs[11] = '{ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         5'b10100, 1};
    vecs[12] = '{ADD,  32'h8000_0000, 32'h8000_0000, 32'h0,         5'b10110, 1};
    vecs[13] = '{SUB,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 5'b00110, 1};
    vecs[14] = '{SLT,  32'h1,         32'hFFFF_FFFF, 32'h0,         5'b10000, 1};
    vecs[15] = '{SLTU, 32'h1,         32'hFFFF_FFFF, 32'h1,         5'b00000, 1};
    vecs[16] = '{4'hF, 32'h12,        32'h34,        32'h0,         5'b10001, 1};
    vecs[17] = '{ADD,  32'h2,         32'h3,         32'h5,         5'b00000, 1};
    vecs[18] = '{4'hB, 32'h1,         32'h1,         32'h0,         5'b10001, 1};
    vecs[19] = '{MUL,  32'h0000_FFFF, 32'h0001_0001, MUL_BIG_RES,   MUL_BIG_FL, MUL_LAT};
    vecs[20] = '{MUL,  32'h0001_0000, 32'h0001_0000, 32'h0,         MUL_EN ? 5'b10000 : 5'b10001, MUL_LAT};
    vecs[21] = '{MUL,  32'h7,         32'h6,         MUL_EN ? 32'h2A : 32'h0,
                 MUL_EN ? 5'b00000 : 5'b10001, MUL_LAT};
    vecs[22] = '{SRA,  32'h4000_0000, 32'hFFFF_FFE2, 32'h1000_0000, 5'b00000, 1};
    vecs[23] = '{SUB,  32'h3,         32'h5,         32'hFFFF_FFFE, 5'b01000, 1};

    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.alu_control = '0;
    bus.out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post-reset");

    // out_ready while idle has no effect.
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("idle out_ready out_valid", bus.out_valid, 1'b0);
    check("idle out_ready in_ready", bus.in_ready, 1'b1);

    for (int i = 0; i < 24; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 0);
    end

    // Result held stable for 3 cycles without out_ready while new input is offered.
    run_vec(vecs[19], "mul hold", 3);
    run_vec(vecs[17], "add hold", 2);

    // Reset ten cycles into a multiply aborts it; the next ADD behaves normally.
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.a           = 32'h0000_FFFF;
    bus.b           = 32'h0001_0001;
    bus.alu_control = MUL;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    check_reset_outputs("abort held");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort released");
    run_vec('{ADD, 32'h1, 32'h1, 32'h2, 5'b00000, 1}, "add after abort", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
